// File: rtl/nunchuck_i2c_responder.sv
// I2C target emulating a Wii Nunchuck: ACKs init writes, tracks a register
// pointer and serves a 6-byte report snapshot from parallel inputs.
module nunchuck_i2c_responder #(
  parameter logic [6:0] ADDR = 7'h52
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] stick_x,
  input  logic [7:0] stick_y,
  input  logic [9:0] accel_x,
  input  logic [9:0] accel_y,
  input  logic [9:0] accel_z,
  input  logic       z,
  input  logic       c,
  output logic       init_done,
  output logic       busy
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SNAP_W  = 6 * BYTE_W;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] S_ADDR     = 3'd1;
  localparam logic [STATE_W-1:0] S_ACK_ADDR = 3'd2;
  localparam logic [STATE_W-1:0] S_WR_BYTE  = 3'd3;
  localparam logic [STATE_W-1:0] S_ACK_WR   = 3'd4;
  localparam logic [STATE_W-1:0] S_RD_BYTE  = 3'd5;
  localparam logic [STATE_W-1:0] S_RD_ACK   = 3'd6;
  localparam logic [STATE_W-1:0] S_IGNORE   = 3'd7;

  // Bus synchronizers, previous-value and registered event flags
  logic scl_m, scl_s, scl_p;
  logic sda_m, sda_s, sda_p;
  logic ev_rise, ev_fall, ev_start, ev_stop;

  logic [STATE_W-1:0] state, state_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0]  shift, shift_n;
  logic [BYTE_W-1:0]  ptr, ptr_n;
  logic [SNAP_W-1:0]  snap, snap_n;
  logic               rw, rw_n;
  logic               first_wr, first_n;
  logic               sda_low, sda_low_n;
  logic               init_n, busy_n;
  logic [BYTE_W-1:0]  cur_byte;

  assign sda = sda_low ? 1'b0 : 1'bz;

  // Idle bus is high, so synchronizers reset to 1 to avoid a false START
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      scl_m    <= 1'b1;
      scl_s    <= 1'b1;
      scl_p    <= 1'b1;
      sda_m    <= 1'b1;
      sda_s    <= 1'b1;
      sda_p    <= 1'b1;
      ev_rise  <= 1'b0;
      ev_fall  <= 1'b0;
      ev_start <= 1'b0;
      ev_stop  <= 1'b0;
    end else begin
      scl_m    <= scl;
      scl_s    <= scl_m;
      scl_p    <= scl_s;
      sda_m    <= sda;
      sda_s    <= sda_m;
      sda_p    <= sda_s;
      ev_rise  <= scl_s & ~scl_p;
      ev_fall  <= ~scl_s & scl_p;
      ev_start <= (scl_s == scl_p) & scl_s & sda_p & ~sda_s;
      ev_stop  <= (scl_s == scl_p) & scl_s & ~sda_p & sda_s;
    end
  end

  // Report byte at the current pointer; out-of-range pointers read 0xFF
  always_comb begin
    cur_byte = 8'hFF;
    case (ptr)
      8'd0:    cur_byte = snap[7:0];
      8'd1:    cur_byte = snap[15:8];
      8'd2:    cur_byte = snap[23:16];
      8'd3:    cur_byte = snap[31:24];
      8'd4:    cur_byte = snap[39:32];
      8'd5:    cur_byte = snap[47:40];
      default: cur_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    snap_n    = snap;
    rw_n      = rw;
    first_n   = first_wr;
    sda_low_n = sda_low;
    init_n    = init_done;

    if (ev_stop) begin
      state_n   = S_IDLE;
      sda_low_n = 1'b0;
    end else if (ev_start) begin
      state_n   = S_ADDR;
      bit_cnt_n = '0;
      sda_low_n = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_WR_BYTE: begin
          if (ev_rise) begin
            shift_n   = {shift[6:0], sda_p};
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end else if (ev_fall && bit_cnt == CNT_W'(8)) begin
            bit_cnt_n = '0;
            if (state == S_ADDR) begin
              if (shift[7:1] == ADDR) begin
                state_n   = S_ACK_ADDR;
                sda_low_n = 1'b1;
                rw_n      = shift[0];
                if (shift[0]) begin
                  snap_n = {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z,
                            accel_z[9:2], accel_y[9:2], accel_x[9:2],
                            stick_y, stick_x};
                end
              end else begin
                state_n = S_IGNORE;
              end
            end else begin
              state_n   = S_ACK_WR;
              sda_low_n = 1'b1;
              if (first_wr) begin
                ptr_n   = shift;
                first_n = 1'b0;
              end else begin
                if ((ptr == 8'hF0 && shift == 8'h55) ||
                    (ptr == 8'h40 && shift == 8'h00)) begin
                  init_n = 1'b1;
                end
                ptr_n = ptr + BYTE_W'(1);
              end
            end
          end
        end
        S_ACK_ADDR: begin
          if (ev_fall) begin
            if (rw) begin
              state_n   = S_RD_BYTE;
              shift_n   = cur_byte;
              sda_low_n = ~cur_byte[7];
            end else begin
              state_n   = S_WR_BYTE;
              first_n   = 1'b1;
              sda_low_n = 1'b0;
            end
          end
        end
        S_ACK_WR: begin
          if (ev_fall) begin
            state_n   = S_WR_BYTE;
            sda_low_n = 1'b0;
          end
        end
        S_RD_BYTE: begin
          if (ev_rise) begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end else if (ev_fall) begin
            if (bit_cnt == CNT_W'(8)) begin
              state_n   = S_RD_ACK;
              sda_low_n = 1'b0;
              bit_cnt_n = '0;
              if (ptr < 8'd6) begin
                ptr_n = (ptr == 8'd5) ? 8'd0 : ptr + BYTE_W'(1);
              end
            end else begin
              shift_n   = {shift[6:0], 1'b1};
              sda_low_n = ~shift[6];
            end
          end
        end
        S_RD_ACK: begin
          // bit 0 of the shift register holds the initiator's ACK/NACK
          if (ev_rise) begin
            shift_n   = {shift[7:1], sda_p};
            bit_cnt_n = CNT_W'(1);
          end else if (ev_fall && bit_cnt == CNT_W'(1)) begin
            bit_cnt_n = '0;
            if (!shift[0]) begin
              state_n   = S_RD_BYTE;
              shift_n   = cur_byte;
              sda_low_n = ~cur_byte[7];
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      snap      <= '0;
      rw        <= 1'b0;
      first_wr  <= 1'b0;
      sda_low   <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      ptr       <= ptr_n;
      snap      <= snap_n;
      rw        <= rw_n;
      first_wr  <= first_n;
      sda_low   <= sda_low_n;
      init_done <= init_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_nunchuck_i2c_responder.sv
// Bench for nunchuck_i2c_responder: bit-banged I2C initiator plus a
// transaction-level model of pointer, init flag and report contents.
module tb_nunchuck_i2c_responder;

  localparam int HALF = 12;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       tb_low = 1'b0;
  wire        sda;
  logic [7:0] stick_x, stick_y;
  logic [9:0] accel_x, accel_y, accel_z;
  logic       z, c;
  logic       init_done, busy;

  int total = 0;
  int bad = 0;

  logic [7:0] m_ptr = 8'h00;
  logic       m_init = 1'b0;
  logic [7:0] m_snap [6];

  int         hook_bit = -1;
  int         hook_kind = 0;
  logic [7:0] hook_val = 8'h00;

  assign sda = tb_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clock = ~clock;

  nunchuck_i2c_responder dut (
    .clock(clock), .rst(rst), .scl(scl), .sda(sda),
    .stick_x(stick_x), .stick_y(stick_y),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .z(z), .c(c), .init_done(init_done), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Report byte derived from the current inputs with plain arithmetic
  function automatic logic [7:0] rep(input int idx);
    int v;
    case (idx)
      0: v = int'(stick_x);
      1: v = int'(stick_y);
      2: v = int'(accel_x) / 4;
      3: v = int'(accel_y) / 4;
      4: v = int'(accel_z) / 4;
      default: v = (int'(accel_z) % 4) * 64 + (int'(accel_y) % 4) * 16 +
                   (int'(accel_x) % 4) * 4 + (c ? 0 : 2) + (z ? 0 : 1);
    endcase
    return 8'(v);
  endfunction

  task automatic bit_xfer(input logic b, output logic s);
    waitc(HALF/2); tb_low = ~b;
    waitc(HALF/2); scl = 1'b1;
    waitc(HALF/2); s = sda;
    waitc(HALF/2); scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      waitc(HALF/2); tb_low = 1'b0;
      waitc(HALF/2); scl = 1'b1;
    end
    waitc(HALF/2); tb_low = 1'b1;
    waitc(HALF/2); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    waitc(HALF/2); tb_low = 1'b1;
    waitc(HALF/2); scl = 1'b1;
    waitc(HALF/2); tb_low = 1'b0;
    waitc(HALF);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  // Returns early (aborted=1) when the reset hook fires mid-byte
  task automatic read_byte(input logic nack, output logic [7:0] b, output logic aborted);
    logic s;
    b = 8'h00;
    aborted = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == hook_bit && hook_kind == 1) stick_x = hook_val;
      if (i == hook_bit && hook_kind == 2) begin
        waitc(HALF/2); tb_low = 1'b0;
        waitc(HALF/2); scl = 1'b1;
        waitc(HALF/2); rst = 1'b0;
        #1;
        check("rst_sda_released", 32'(sda), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        aborted = 1'b1;
        return;
      end
      bit_xfer(1'b1, s);
      b = {b[6:0], s};
    end
    bit_xfer(nack, s);
  endtask

  task automatic do_write(input logic [7:0] adr, input int n,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic       a;
    logic [7:0] bs [3];
    logic       match;
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    match = (adr[7:1] == 7'h52) && !adr[0];
    i2c_start();
    write_byte(adr, a);
    check($sformatf("wr_addr_ack_%02h", adr), 32'(a), match ? 32'h0 : 32'h1);
    if (match) check("busy_in_txn", 32'(busy), 32'h1);
    for (int i = 0; i < n; i++) begin
      write_byte(bs[i], a);
      check($sformatf("wr_data_ack_%0d", i), 32'(a), match ? 32'h0 : 32'h1);
      if (match) begin
        if (i == 0) m_ptr = bs[0];
        else begin
          if ((m_ptr == 8'hF0 && bs[i] == 8'h55) || (m_ptr == 8'h40 && bs[i] == 8'h00))
            m_init = 1'b1;
          m_ptr = m_ptr + 8'd1;
        end
      end
    end
    i2c_stop();
    check("busy_after_stop", 32'(busy), 32'h0);
    check("sda_after_stop", 32'(sda), 32'h1);
    check("init_done", 32'(init_done), 32'(m_init));
  endtask

  task automatic take_snap();
    for (int i = 0; i < 6; i++) m_snap[i] = rep(i);
  endtask

  task automatic do_read(input int n);
    logic       a, ab;
    logic [7:0] b, exp;
    take_snap();
    i2c_start();
    write_byte(8'hA5, a);
    check("rd_addr_ack", 32'(a), 32'h0);
    for (int k = 0; k < n; k++) begin
      exp = (m_ptr < 8'd6) ? m_snap[m_ptr] : 8'hFF;
      read_byte(k == n - 1, b, ab);
      check($sformatf("rd_byte%0d_ptr%0d", k, m_ptr), 32'(b), 32'(exp));
      if (m_ptr < 8'd6) m_ptr = (m_ptr == 8'd5) ? 8'd0 : m_ptr + 8'd1;
    end
    check("busy_after_nack", 32'(busy), 32'h1);
    i2c_stop();
    check("busy_after_rd_stop", 32'(busy), 32'h0);
  endtask

  task automatic randomize_inputs();
    stick_x = 8'($urandom);
    stick_y = 8'($urandom);
    accel_x = 10'($urandom);
    accel_y = 10'($urandom);
    accel_z = 10'($urandom);
    z = 1'($urandom);
    c = 1'($urandom);
  endtask

  initial begin
    logic       a, ab;
    logic [7:0] b;
    logic [7:0] p, d;
    logic [6:0] a7;
    int         op;

    randomize_inputs();
    waitc(4);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_init", 32'(init_done), 32'h0);
    check("reset_sda", 32'(sda), 32'h1);
    rst = 1'b1;
    waitc(8);

    // Address match only
    i2c_start();
    write_byte(8'hA4, a);
    check("addr_a4_ack", 32'(a), 32'h0);
    check("addr_busy", 32'(busy), 32'h1);
    i2c_stop();
    check("addr_stop_busy", 32'(busy), 32'h0);
    check("addr_stop_sda", 32'(sda), 32'h1);

    // Wrong address, init pattern must be ignored
    do_write(8'hA6, 2, 8'hF0, 8'h55, 8'h00);

    // Init sequences
    do_write(8'hA4, 2, 8'hF0, 8'h55, 8'h00);
    do_write(8'hA4, 2, 8'hFB, 8'h00, 8'h00);
    rst = 1'b0; waitc(3); rst = 1'b1; waitc(4);
    m_init = 1'b0; m_ptr = 8'h00;
    check("init_after_reset", 32'(init_done), 32'h0);

    // Report contents
    stick_x = 8'h80; stick_y = 8'h7F;
    accel_x = 10'h2A5; accel_y = 10'h1FF; accel_z = 10'h003;
    z = 1'b1; c = 1'b0;
    do_write(8'hA4, 1, 8'h00, 8'h00, 8'h00);
    do_read(6);
    do_write(8'hA4, 1, 8'h00, 8'h00, 8'h00);
    do_read(7);

    // Snapshot stability across a mid-byte input change
    do_write(8'hA4, 1, 8'h00, 8'h00, 8'h00);
    hook_kind = 1; hook_bit = 3; hook_val = 8'h10;
    do_read(1);
    hook_kind = 0; hook_bit = -1;
    do_write(8'hA4, 1, 8'h00, 8'h00, 8'h00);
    do_read(1);

    // Reset during bit 3 of byte 2, then pointer restarts at 0
    do_write(8'hA4, 1, 8'h00, 8'h00, 8'h00);
    take_snap();
    i2c_start();
    write_byte(8'hA5, a);
    check("rstrd_addr_ack", 32'(a), 32'h0);
    for (int k = 0; k < 2; k++) begin
      read_byte(1'b0, b, ab);
      check($sformatf("rstrd_byte%0d", k), 32'(b), 32'(m_snap[k]));
    end
    hook_kind = 2; hook_bit = 3;
    read_byte(1'b0, b, ab);
    check("rstrd_aborted", 32'(ab), 32'h1);
    hook_kind = 0; hook_bit = -1;
    waitc(4);
    rst = 1'b1;
    m_ptr = 8'h00; m_init = 1'b0;
    waitc(HALF);
    do_read(1);

    // Randomized transactions against the model
    for (int t = 0; t < 16; t++) begin
      randomize_inputs();
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          case ($urandom_range(0, 3))
            0: p = 8'hF0;
            1: p = 8'h40;
            2: p = 8'($urandom_range(0, 7));
            default: p = 8'($urandom);
          endcase
          d = ($urandom_range(0, 1) == 0) ? ((p == 8'hF0) ? 8'h55 : 8'h00) : 8'($urandom);
          do_write(8'hA4, $urandom_range(1, 3), p, d, 8'($urandom));
        end
        1, 2: do_read($urandom_range(1, 8));
        default: begin
          a7 = 7'($urandom);
          if (a7 == 7'h52) a7 = 7'h53;
          do_write({a7, 1'($urandom)}, $urandom_range(0, 2), 8'hF0, 8'h55, 8'h00);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
